// File: rtl/forwarding_scoreboard.sv
// rtl/forwarding_scoreboard.sv - multi-port operand forwarding scoreboard with flush, stall watchdog and issue gating
// Optional statistics counters are built when FORWARDING_SCOREBOARD_STATS_EN is defined.
module forwarding_scoreboard #(
  parameter int READ_PORTS  = 2,
  parameter int STAGES      = 3,
  parameter int XLEN        = 32,
  parameter int REG_ADDR_W  = 5,
  parameter int STALL_LIMIT = 15
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_advance,
  input  logic                           i_flush,
  input  logic                           i_issue_valid,
  input  logic                           i_issue_we,
  input  logic [REG_ADDR_W-1:0]          i_issue_rd,
  output logic                           o_issue_ready,
  input  logic [READ_PORTS*REG_ADDR_W-1:0] i_rd_addr,
  input  logic [READ_PORTS-1:0]          i_rd_used,
  input  logic [READ_PORTS*XLEN-1:0]     i_rf_data,
  input  logic [STAGES*XLEN-1:0]         i_stage_data,
  input  logic [STAGES-1:0]              i_stage_data_valid,
  output logic [READ_PORTS*XLEN-1:0]     o_fwd_data,
  output logic [READ_PORTS-1:0]          o_fwd_hit,
  output logic [READ_PORTS-1:0]          o_stall,
  output logic                           o_watchdog
`ifdef FORWARDING_SCOREBOARD_STATS_EN
  ,
  output logic [31:0]                    o_fwd_count,
  output logic [31:0]                    o_stall_cycles
`endif
);

  localparam int CNT_W = $clog2(STALL_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STALL_LIMIT);

  logic [STAGES-1:0]     r_valid;
  logic [REG_ADDR_W-1:0] r_addr [STAGES];
  logic [CNT_W-1:0]      r_stall_cnt;
  logic [CNT_W-1:0]      w_cnt_next;
  logic                  r_watchdog;
  logic                  w_match;
  logic                  w_win_rdy;
  logic [XLEN-1:0]       w_win_data;
  logic [REG_ADDR_W-1:0] w_port_addr;

  // x0 is never recorded, so reads of x0 can never see a hazard.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_valid <= '0;
      for (int i = 0; i < STAGES; i++) r_addr[i] <= '0;
    end else if (i_advance) begin
      r_valid[0] <= i_issue_valid & i_issue_we & o_issue_ready & ~i_flush & (i_issue_rd != '0);
      r_addr[0]  <= i_issue_rd;
      for (int i = 1; i < STAGES; i++) begin
        r_valid[i] <= r_valid[i-1];
        r_addr[i]  <= r_addr[i-1];
      end
    end else if (i_flush) begin
      r_valid[0] <= 1'b0;
    end
  end

  // Scan oldest to youngest so the youngest match overrides; no fallback to older slots.
  always_comb begin
    o_fwd_data  = '0;
    o_fwd_hit   = '0;
    o_stall     = '0;
    w_match     = 1'b0;
    w_win_rdy   = 1'b0;
    w_win_data  = '0;
    w_port_addr = '0;
    for (int p = 0; p < READ_PORTS; p++) begin
      w_match     = 1'b0;
      w_win_rdy   = 1'b0;
      w_win_data  = '0;
      w_port_addr = i_rd_addr[p*REG_ADDR_W +: REG_ADDR_W];
      for (int i = STAGES - 1; i >= 0; i--) begin
        if (r_valid[i] && (r_addr[i] == w_port_addr) && (w_port_addr != '0)) begin
          w_match    = 1'b1;
          w_win_rdy  = i_stage_data_valid[i];
          w_win_data = i_stage_data[i*XLEN +: XLEN];
        end
      end
      if (w_match && w_win_rdy) begin
        o_fwd_data[p*XLEN +: XLEN] = w_win_data;
        o_fwd_hit[p]               = 1'b1;
      end else begin
        o_fwd_data[p*XLEN +: XLEN] = i_rf_data[p*XLEN +: XLEN];
        o_stall[p]                 = w_match & i_rd_used[p];
      end
    end
  end

  assign o_issue_ready = ~(|o_stall);

  always_comb begin
    w_cnt_next = r_stall_cnt;
    if (i_flush || o_issue_ready) begin
      w_cnt_next = '0;
    end else if (i_issue_valid && (r_stall_cnt != LIMIT)) begin
      w_cnt_next = r_stall_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_stall_cnt <= '0;
      r_watchdog  <= 1'b0;
    end else begin
      r_stall_cnt <= w_cnt_next;
      r_watchdog  <= r_watchdog | (w_cnt_next == LIMIT);
    end
  end

  assign o_watchdog = r_watchdog;

`ifdef FORWARDING_SCOREBOARD_STATS_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_fwd_count    <= '0;
      o_stall_cycles <= '0;
    end else begin
      if (i_issue_valid && |(o_fwd_hit & i_rd_used)) o_fwd_count <= o_fwd_count + 32'd1;
      if (i_issue_valid && !o_issue_ready) o_stall_cycles <= o_stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_forwarding_scoreboard.sv
// tb/tb_forwarding_scoreboard.sv - self-checking bench for forwarding_scoreboard
module tb_forwarding_scoreboard;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_advance, i_flush, i_issue_valid, i_issue_we;
  logic [4:0]  i_issue_rd;
  logic        o_issue_ready;
  logic [9:0]  i_rd_addr;
  logic [1:0]  i_rd_used;
  logic [63:0] i_rf_data;
  logic [95:0] i_stage_data;
  logic [2:0]  i_stage_data_valid;
  logic [63:0] o_fwd_data;
  logic [1:0]  o_fwd_hit, o_stall;
  logic        o_watchdog;
`ifdef FORWARDING_SCOREBOARD_STATS_EN
  logic [31:0] o_fwd_count, o_stall_cycles;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [68:0] sb[$];
  logic [68:0] e;
  logic [68:0] obs;
  assign obs = {o_fwd_data, o_fwd_hit, o_stall, o_issue_ready};

  localparam logic [63:0] RF = {32'h11, 32'h22};
  localparam logic [68:0] EXP_IDLE = {RF, 2'b00, 2'b00, 1'b1};

  forwarding_scoreboard dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_advance(i_advance), .i_flush(i_flush),
    .i_issue_valid(i_issue_valid), .i_issue_we(i_issue_we), .i_issue_rd(i_issue_rd),
    .o_issue_ready(o_issue_ready), .i_rd_addr(i_rd_addr), .i_rd_used(i_rd_used),
    .i_rf_data(i_rf_data), .i_stage_data(i_stage_data), .i_stage_data_valid(i_stage_data_valid),
    .o_fwd_data(o_fwd_data), .o_fwd_hit(o_fwd_hit), .o_stall(o_stall), .o_watchdog(o_watchdog)
`ifdef FORWARDING_SCOREBOARD_STATS_EN
    , .o_fwd_count(o_fwd_count), .o_stall_cycles(o_stall_cycles)
`endif
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle();
    i_advance = 0; i_flush = 0; i_issue_valid = 0; i_issue_we = 0; i_issue_rd = 0;
    i_rd_addr = 0; i_rd_used = 2'b11; i_rf_data = RF;
    i_stage_data = {32'hC2, 32'hB1, 32'hA0}; i_stage_data_valid = 3'b000;
  endtask

  task automatic issue(input logic [4:0] rd, input logic fl);
    i_issue_valid = 1; i_issue_we = 1; i_issue_rd = rd; i_advance = 1; i_flush = fl; i_rd_addr = 0;
    tick();
    idle();
  endtask

  task automatic drain();
    idle(); i_advance = 1;
    repeat (3) tick();
    idle();
  endtask

  task automatic test_reset();
    idle(); i_rst = 1;
    i_rd_addr = {5'd5, 5'd3};
    sb.push_back(EXP_IDLE);
    #1;
    e = sb.pop_front(); n_checks++;
    if (obs !== e) begin n_errors++; $display("FAIL reset_outputs: got %h expected %h", obs, e); end
    n_checks++;
    if (o_watchdog !== 1'b0) begin n_errors++; $display("FAIL reset_watchdog: got %b expected 0", o_watchdog); end
    tick(); tick();
    i_rst = 0;
    tick();
  endtask

  task automatic test_forward();
    issue(5'd5, 1'b0);
    i_rd_addr = {5'd3, 5'd5}; i_stage_data[31:0] = 32'hAA; i_stage_data_valid = 3'b001;
    sb.push_back({32'h11, 32'hAA, 2'b01, 2'b00, 1'b1});
    #1;
    e = sb.pop_front(); n_checks++;
    if (obs !== e) begin n_errors++; $display("FAIL fwd_slot0: got %h expected %h", obs, e); end
    i_stage_data_valid = 3'b000;
    sb.push_back({RF, 2'b00, 2'b01, 1'b0});
    #1;
    e = sb.pop_front(); n_checks++;
    if (obs !== e) begin n_errors++; $display("FAIL stall_slot0: got %h expected %h", obs, e); end
    i_advance = 1; tick(); i_advance = 0;
    i_rd_addr = {5'd5, 5'd5}; i_stage_data[63:32] = 32'hCC; i_stage_data_valid = 3'b010;
    sb.push_back({32'hCC, 32'hCC, 2'b11, 2'b00, 1'b1});
    #1;
    e = sb.pop_front(); n_checks++;
    if (obs !== e) begin n_errors++; $display("FAIL fwd_slot1_both_ports: got %h expected %h", obs, e); end
    drain();
    i_rd_addr = {5'd5, 5'd5}; i_stage_data_valid = 3'b111;
    sb.push_back(EXP_IDLE);
    #1;
    e = sb.pop_front(); n_checks++;
    if (obs !== e) begin n_errors++; $display("FAIL drained_no_hit: got %h expected %h", obs, e); end
  endtask

  task automatic test_no_fallback();
    issue(5'd7, 1'b0);
    issue(5'd7, 1'b0);
    i_rd_addr = {5'd0, 5'd7}; i_rd_used = 2'b01;
    i_stage_data[63:32] = 32'hBB; i_stage_data_valid = 3'b010;
    sb.push_back({RF, 2'b00, 2'b01, 1'b0});
    #1;
    e = sb.pop_front(); n_checks++;
    if (obs !== e) begin n_errors++; $display("FAIL no_fallback_used: got %h expected %h", obs, e); end
    i_rd_used = 2'b00;
    sb.push_back(EXP_IDLE);
    #1;
    e = sb.pop_front(); n_checks++;
    if (obs !== e) begin n_errors++; $display("FAIL no_fallback_unused: got %h expected %h", obs, e); end
    drain();
  endtask

  task automatic test_x0();
    issue(5'd0, 1'b0);
    i_rd_addr = {5'd0, 5'd0}; i_stage_data_valid = 3'b111;
    sb.push_back(EXP_IDLE);
    #1;
    e = sb.pop_front(); n_checks++;
    if (obs !== e) begin n_errors++; $display("FAIL x0_no_hazard: got %h expected %h", obs, e); end
    drain();
  endtask

  task automatic test_flush();
    issue(5'd9, 1'b1);
    i_rd_addr = {5'd9, 5'd9}; i_stage_data_valid = 3'b111;
    sb.push_back(EXP_IDLE);
    #1;
    e = sb.pop_front(); n_checks++;
    if (obs !== e) begin n_errors++; $display("FAIL flush_advance_bubble: got %h expected %h", obs, e); end
    drain();
    issue(5'd9, 1'b0);
    i_flush = 1; tick(); i_flush = 0;
    i_rd_addr = {5'd9, 5'd9}; i_stage_data_valid = 3'b000;
    sb.push_back(EXP_IDLE);
    #1;
    e = sb.pop_front(); n_checks++;
    if (obs !== e) begin n_errors++; $display("FAIL flush_hold_clears_slot0: got %h expected %h", obs, e); end
    drain();
    // hazard parked in slot 1 so a hold-flush leaves it in place but resets the counter
    issue(5'd4, 1'b0);
    i_advance = 1; tick(); idle();
    i_issue_valid = 1; i_rd_addr = {5'd0, 5'd4}; i_rd_used = 2'b01;
    sb.push_back({RF, 2'b00, 2'b01, 1'b0});
    #1;
    e = sb.pop_front(); n_checks++;
    if (obs !== e) begin n_errors++; $display("FAIL slot1_load_use: got %h expected %h", obs, e); end
    repeat (10) tick();
    i_flush = 1; tick(); i_flush = 0;
    repeat (10) tick();
    n_checks++;
    if (o_watchdog !== 1'b0) begin n_errors++; $display("FAIL flush_clears_stall_cnt: got %b expected 0", o_watchdog); end
    drain();
  endtask

  task automatic test_watchdog();
    issue(5'd4, 1'b0);
    i_issue_valid = 1; i_rd_addr = {5'd0, 5'd4}; i_rd_used = 2'b01;
    repeat (14) tick();
    n_checks++;
    if (o_watchdog !== 1'b0) begin n_errors++; $display("FAIL watchdog_14: got %b expected 0", o_watchdog); end
    tick();
    n_checks++;
    if (o_watchdog !== 1'b1) begin n_errors++; $display("FAIL watchdog_15: got %b expected 1", o_watchdog); end
    i_rd_used = 2'b00;
    tick(); tick();
    n_checks++;
    if ({o_watchdog, o_issue_ready} !== 2'b11) begin n_errors++; $display("FAIL watchdog_sticky: got %b expected 11", {o_watchdog, o_issue_ready}); end
    i_rd_used = 2'b01;
    #2 i_rst = 1;
    sb.push_back(EXP_IDLE);
    #1;
    e = sb.pop_front(); n_checks++;
    if (obs !== e) begin n_errors++; $display("FAIL async_reset_outputs: got %h expected %h", obs, e); end
    n_checks++;
    if (o_watchdog !== 1'b0) begin n_errors++; $display("FAIL async_reset_watchdog: got %b expected 0", o_watchdog); end
    tick();
    i_rst = 0;
    idle();
  endtask

  initial begin
    fork
      begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
      end
    join_none
    test_reset();
    test_forward();
    test_no_fallback();
    test_x0();
    test_flush();
    test_watchdog();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/forwarding_scoreboard.md
Name: forwarding_scoreboard

Overview:
- Parametrised successor to the per-operand forwarder used in the decode stage.
- Tracks in-flight register writes in an internal shift pipeline of STAGES slots, one slot per downstream stage (execute-out, memory-out, writeback-in, ...).
- Serves READ_PORTS decode operands with forwarded data and per-port stall.
- Adds flush handling, a stall-duration watchdog and issue gating, none of which the single forwarder provides.

Parameters:
- READ_PORTS, 2: number of decode operand read ports.
- STAGES, 3: number of tracked in-flight slots; slot 0 is the youngest.
- XLEN, 32: data width.
- REG_ADDR_W, 5: register address width.
- STALL_LIMIT, 15: consecutive stall cycles before the watchdog fires; must be at least 1.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- advance  in  1  pipeline moves this cycle.
- flush  in  1  squash the instruction entering slot 0.
- issue_valid  in  1  decode holds a valid instruction.
- issue_we  in  1  that instruction writes a register.
- issue_rd  in  REG_ADDR_W  its destination register.
- issue_ready  out  1  no stall on any used port.
- rd_addr  in  READ_PORTS*REG_ADDR_W  operand addresses; port p occupies bits [p*REG_ADDR_W +: REG_ADDR_W].
- rd_used  in  READ_PORTS  the operand is actually consumed.
- rf_data  in  READ_PORTS*XLEN  register file read data.
- stage_data  in  STAGES*XLEN  result currently held by each downstream stage.
- stage_data_valid  in  STAGES  that stage's result is available (e.g. 0 for a load in execute).
- fwd_data  out  READ_PORTS*XLEN  operand value after forwarding.
- fwd_hit  out  READ_PORTS  operand was forwarded.
- stall  out  READ_PORTS  operand hazard not yet resolvable.
- watchdog  out  1  sticky stall-timeout flag.

Behaviour:
- Slot state per slot i: valid_i and addr_i. All slots are invalid after reset.
- Clock edge with advance=1:
  - slot0 takes valid = issue_valid & issue_we & issue_ready & !flush, and addr = issue_rd.
  - slot i takes slot i-1 for i ≥ 1.
  - The oldest slot drops out.
- Clock edge with advance=0: all slots hold, except that flush=1 clears valid_0.
- A slot written with addr=0 is stored as invalid, so x0 never produces a hazard.
- Forwarding is combinational, with zero-cycle latency from rd_addr to fwd_data/stall. For each port p:
  - A match is a slot i with valid_i=1, addr_i=rd_addr[p] and rd_addr[p]≠0.
  - The lowest-index (youngest) matching slot wins.
  - If a winner exists and stage_data_valid[i]=1: fwd_data=stage_data[i], fwd_hit=1, stall=0.
  - If a winner exists and stage_data_valid[i]=0: stall=rd_used[p], fwd_data=rf_data, fwd_hit=0. An older matching slot is never used as a fallback.
  - If there is no match: fwd_data=rf_data[p], fwd_hit=0, stall=0.
- issue_ready = !(|stall).
- Watchdog:
  - stall_cnt, width $clog2(STALL_LIMIT+1), increments on each edge where issue_valid & !issue_ready. It saturates at STALL_LIMIT.
  - Any edge with issue_ready=1 or flush=1 clears it.
  - When the counter reaches STALL_LIMIT, watchdog is set and stays set until rst.
- Reset values: all slots invalid, stall_cnt=0, watchdog=0. With all slots invalid, fwd_hit=0, stall=0 and fwd_data=rf_data.
- Reset asserted mid-operation clears everything asynchronously. Outputs reflect the empty scoreboard in the same cycle.
- flush and advance in the same cycle: the bubble enters slot 0 and older slots still shift.

Optional Feature:
- Macro: FORWARDING_SCOREBOARD_STATS_EN.
- When defined, adds output fwd_count (32 bits), which counts edges where |(fwd_hit & rd_used) and issue_valid.
- Also adds output stall_cycles (32 bits), which counts edges where issue_valid & !issue_ready.
- Both counters wrap at 2^32 and clear on rst.
- When undefined, neither port nor counter exists and the behaviour is otherwise identical.

Test Plan:
1. Reset, then rd_addr={5,3} with rf_data={0x11,0x22} -> fwd_data={0x11,0x22}, fwd_hit=00, stall=00, issue_ready=1.
2. Issue rd=5 with advance=1. Next cycle set stage_data[0]=0xAA, stage_data_valid[0]=1, rd_addr[0]=5 -> fwd_data[0]=0xAA, fwd_hit[0]=1.
3. rd=7 in slot 0 (stage_data_valid[0]=0) and slot 1 (stage_data_valid[1]=1, stage_data[1]=0xBB). Read 7 with rd_used=1 -> stall=1 and issue_ready=0, not 0xBB. Repeat with rd_used=0 -> stall=0.
4. Issue rd=0 with we=1, then read x0 -> stall=0, fwd_hit=0, fwd_data=rf_data.
5. Hold a load-use stall with issue_valid=1 for 15 cycles (STALL_LIMIT=15) -> watchdog=1 on the 15th edge and stays 1 after the stall clears, until rst.
6. Issue rd=9 with flush=1 and advance=1 -> slot 0 invalid, a read of 9 does not hit, and stall_cnt=0.
